rs_erasure_decoder_pipe: RTL and testbench

Parametrised, pipelined RS(K+2,K) decoder over GF(2^8) for the rank-level ECC path. It generalises the combinational 10/8 erasure decoder to any data-symbol count K. It adds three things: a no-erasure single-symbol correction mode, single-erasure verification, and valid/ready flow control with saturating CE/DUE statistics counters. It sits between the rank read-data capture and the memory-controller return path, and takes chip-fail (erasure) hints from the DUE/chip-tracking logic.

---
 rtl/rs_erasure_decoder_pipe.sv | 276 +++++++++++++++++++++++++++
 tb/tb_rs_erasure_decoder_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_erasure_decoder_pipe.sv
// Pipelined RS(K+2,K) GF(2^8) decoder: erasure recovery for up to two symbols, single-error
// correction with no erasures, valid/ready flow control and saturating CE/DUE counters.
module rs_erasure_decoder_pipe #(
  parameter int K     = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [(K+2)*8-1:0]   in_codeword,
  input  logic [K+1:0]         in_erasure,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [K*8-1:0]       out_data,
  output logic [1:0]           out_result,
  output logic [1:0]           out_fix_cnt,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     ce_cnt,
  output logic [CNT_W-1:0]     due_cnt
);
  localparam int N      = K + 2;
  localparam int STAGES = 3;
  localparam logic [7:0] KB  = 8'(K);
  localparam logic [7:0] KB1 = 8'(K + 1);

  typedef enum logic [1:0] {RES_NE = 2'b00, RES_CE = 2'b01, RES_DUE = 2'b10} res_e;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, t;
    r = 8'h00;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) r = r ^ t;
      t = xtime(t);
    end
    return r;
  endfunction

  function automatic logic [2047:0] gen_exp();
    logic [2047:0] tab;
    logic [7:0]    v;
    tab = '0;
    v   = 8'h01;
    for (int n = 0; n < 256; n++) begin
      tab[n*8 +: 8] = v;
      v = xtime(v);
    end
    return tab;
  endfunction

  function automatic logic [2047:0] gen_log();
    logic [2047:0] e, tab;
    e   = gen_exp();
    tab = '0;
    for (int n = 0; n < 255; n++) tab[int'(e[n*8 +: 8])*8 +: 8] = 8'(n);
    return tab;
  endfunction

  localparam logic [2047:0] EXP_T = gen_exp();
  localparam logic [2047:0] LOG_T = gen_log();

  function automatic logic [7:0] gf_exp(input logic [7:0] n);
    return EXP_T[{n, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] gf_log(input logic [7:0] x);
    return LOG_T[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] gf_div(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    d = {1'b0, gf_log(a)} + 9'd255 - {1'b0, gf_log(b)};
    if (d >= 9'd255) d = d - 9'd255;
    return (a == 8'h00) ? 8'h00 : gf_exp(d[7:0]);
  endfunction

  logic                adv;
  logic [STAGES:1]     vld_pipe_q;

  assign adv       = !vld_pipe_q[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[STAGES];

  // Stage 1: syndromes and erasure positions
  logic [7:0]     s0_d, s1_d, ei_d, ej_d;
  logic [1:0]     ec_d;
  logic [7:0]     s0_q, s1_q, ei_q, ej_q;
  logic [1:0]     ec_q;
  logic [K*8-1:0] d1_q;

  always_comb begin
    s0_d = in_codeword[8 +: 8];
    s1_d = in_codeword[0 +: 8];
    for (int k = 0; k < K; k++) begin
      s0_d = s0_d ^ in_codeword[(N-1-k)*8 +: 8];
      s1_d = s1_d ^ gf_mul(gf_exp(8'(k)), in_codeword[(N-1-k)*8 +: 8]);
    end
    ec_d = 2'd0;
    ei_d = 8'h00;
    ej_d = 8'h00;
    for (int k = 0; k < N; k++) begin
      if (in_erasure[k]) begin
        if (ec_d == 2'd0)      ei_d = 8'(k);
        else if (ec_d == 2'd1) ej_d = 8'(k);
        if (ec_d != 2'd3) ec_d = ec_d + 2'd1;
      end
    end
  end

  // Stage 2: error values and where to apply them (ua/ub gate the data-symbol fixes)
  logic [7:0] alpha_i, alpha_j, ea_d, eb_d, la_d, lb_d;
  logic [8:0] ld;
  logic       ua_d, ub_d, syn_nz;
  res_e       res_d;
  logic [1:0] fc_d;
  logic [7:0] ea_q, eb_q, la_q, lb_q;
  logic       ua_q, ub_q;
  res_e       res_q;
  logic [1:0] fc_q;
  logic [K*8-1:0] d2_q;

  always_comb begin
    res_d   = RES_NE;
    ea_d    = 8'h00;
    eb_d    = 8'h00;
    la_d    = ei_q;
    lb_d    = ej_q;
    ua_d    = 1'b0;
    ub_d    = 1'b0;
    alpha_i = gf_exp(ei_q);
    alpha_j = gf_exp(ej_q);
    syn_nz  = (s0_q != 8'h00) || (s1_q != 8'h00);
    ld      = {1'b0, gf_log(s1_q)} + 9'd255 - {1'b0, gf_log(s0_q)};
    if (ld >= 9'd255) ld = ld - 9'd255;
    case (ec_q)
      2'd0: if (syn_nz) begin
        if (s0_q != 8'h00 && s1_q != 8'h00) begin
          if (ld < {1'b0, KB}) begin
            res_d = RES_CE;
            la_d  = ld[7:0];
            ea_d  = s0_q;
            ua_d  = 1'b1;
          end else begin
            res_d = RES_DUE;
          end
        end else begin
          // lone parity error: exactly one of these is nonzero
          res_d = RES_CE;
          ea_d  = s0_q;
          eb_d  = s1_q;
        end
      end
      2'd1: if (syn_nz) begin
        if (ei_q < KB) begin
          if (s1_q == gf_mul(alpha_i, s0_q)) begin
            res_d = RES_CE;
            ea_d  = s0_q;
            ua_d  = 1'b1;
          end else res_d = RES_DUE;
        end else if (ei_q == KB) begin
          if (s1_q == 8'h00) begin
            res_d = RES_CE;
            ea_d  = s0_q;
          end else res_d = RES_DUE;
        end else begin
          if (s0_q == 8'h00) begin
            res_d = RES_CE;
            ea_d  = s1_q;
          end else res_d = RES_DUE;
        end
      end
      2'd2: if (syn_nz) begin
        res_d = RES_CE;
        ua_d  = ei_q < KB;
        ub_d  = ej_q < KB;
        if (ej_q < KB) begin
          ea_d = gf_div(gf_mul(s0_q, alpha_j) ^ s1_q, alpha_i ^ alpha_j);
          eb_d = s0_q ^ ea_d;
        end else if (ej_q == KB) begin
          ea_d = gf_div(s1_q, alpha_i);
          eb_d = s0_q ^ ea_d;
        end else if (ei_q < KB) begin
          ea_d = s0_q;
          eb_d = s1_q ^ gf_mul(alpha_i, s0_q);
        end else begin
          ea_d = s0_q;
          eb_d = (ej_q == KB1) ? s1_q : 8'h00;
        end
      end
      default: res_d = RES_DUE;
    endcase
    fc_d = (res_d == RES_CE) ? ({1'b0, ea_d != 8'h00} + {1'b0, eb_d != 8'h00}) : 2'd0;
  end

  // Stage 3: apply fixes to data symbols
  logic [K*8-1:0] out_data_d, out_data_q;
  logic [1:0]     out_result_q, out_fix_q;

  for (genvar g = 0; g < K; g++) begin : g_fix
    logic [7:0] fa, fb;
    assign fa = (ua_q && la_q == 8'(g)) ? ea_q : 8'h00;
    assign fb = (ub_q && lb_q == 8'(g)) ? eb_q : 8'h00;
    assign out_data_d[(K-1-g)*8 +: 8] = d2_q[(K-1-g)*8 +: 8] ^ fa ^ fb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q   <= '0;
      s0_q         <= '0;
      s1_q         <= '0;
      ei_q         <= '0;
      ej_q         <= '0;
      ec_q         <= '0;
      d1_q         <= '0;
      ea_q         <= '0;
      eb_q         <= '0;
      la_q         <= '0;
      lb_q         <= '0;
      ua_q         <= 1'b0;
      ub_q         <= 1'b0;
      res_q        <= RES_NE;
      fc_q         <= '0;
      d2_q         <= '0;
      out_data_q   <= '0;
      out_result_q <= '0;
      out_fix_q    <= '0;
    end else if (adv) begin
      vld_pipe_q   <= {vld_pipe_q[STAGES-1:1], in_valid};
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      ei_q         <= ei_d;
      ej_q         <= ej_d;
      ec_q         <= ec_d;
      d1_q         <= in_codeword[N*8-1 -: K*8];
      ea_q         <= ea_d;
      eb_q         <= eb_d;
      la_q         <= la_d;
      lb_q         <= lb_d;
      ua_q         <= ua_d;
      ub_q         <= ub_d;
      res_q        <= res_d;
      fc_q         <= fc_d;
      d2_q         <= d1_q;
      out_data_q   <= out_data_d;
      out_result_q <= res_q;
      out_fix_q    <= fc_q;
    end
  end

  assign out_data    = out_data_q;
  assign out_result  = out_result_q;
  assign out_fix_cnt = out_fix_q;

  logic [CNT_W-1:0] ce_q, due_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_q  <= '0;
      due_q <= '0;
    end else if (clr_stats) begin
      ce_q  <= '0;
      due_q <= '0;
    end else if (out_valid && out_ready) begin
      if (out_result_q == RES_CE && ce_q != '1)   ce_q  <= ce_q + 1'b1;
      if (out_result_q == RES_DUE && due_q != '1) due_q <= due_q + 1'b1;
    end
  end

  assign ce_cnt  = ce_q;
  assign due_cnt = due_q;
endmodule

// File: tb/tb_rs_erasure_decoder_pipe.sv
// Directed bench for rs_erasure_decoder_pipe (K=8): latency, correction modes, counters,
// backpressure ordering and mid-flight reset.
module tb_rs_erasure_decoder_pipe;
  localparam int K  = 8;
  localparam int N  = K + 2;
  localparam int CW = N * 8;
  localparam int DW = K * 8;
  localparam logic [1:0] NE = 2'b00, CE = 2'b01, DUE = 2'b10;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready, clr_stats;
  logic [CW-1:0] in_codeword;
  logic [N-1:0]  in_erasure;
  logic [DW-1:0] out_data;
  logic [1:0]    out_result, out_fix_cnt;
  logic [15:0]   ce_cnt, due_cnt;

  rs_erasure_decoder_pipe #(.K(K), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_codeword(in_codeword), .in_erasure(in_erasure), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_result(out_result),
    .out_fix_cnt(out_fix_cnt), .clr_stats(clr_stats), .ce_cnt(ce_cnt), .due_cnt(due_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  int exp_ce = 0, exp_due = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, t;
    r = 0;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) r = r ^ t;
      t = xt(t);
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
    logic [7:0] p0, p1, ap;
    p0 = 0;
    p1 = 0;
    ap = 8'h01;
    for (int k = 0; k < K; k++) begin
      p0 = p0 ^ d[(K-1-k)*8 +: 8];
      p1 = p1 ^ mul(ap, d[(K-1-k)*8 +: 8]);
      ap = xt(ap);
    end
    return {d, p0, p1};
  endfunction

  function automatic logic [CW-1:0] sm(input int idx, input logic [7:0] v);
    logic [CW-1:0] m;
    m = '0;
    m[(N-1-idx)*8 +: 8] = v;
    return m;
  endfunction

  task automatic bump(input logic [1:0] r);
    if (r == CE) exp_ce++;
    if (r == DUE) exp_due++;
  endtask

  task automatic run_vec(input string tag, input logic [CW-1:0] cw, input logic [N-1:0] er,
                         input logic [DW-1:0] ed, input logic [1:0] eres, input logic [1:0] efc);
    @(negedge clk);
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_codeword = cw;
    in_erasure  = er;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    in_codeword = '0;
    in_erasure  = '0;
    chk({tag, "_lat1"}, out_valid, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, out_valid, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_res"}, out_result, eres);
    chk({tag, "_fix"}, out_fix_cnt, efc);
    @(posedge clk); #1;
    bump(eres);
    chk({tag, "_ce_cnt"}, ce_cnt, exp_ce);
    chk({tag, "_due_cnt"}, due_cnt, exp_due);
  endtask

  logic [DW-1:0] D;
  logic [CW-1:0] bcw [4];
  logic [N-1:0]  ber [4];
  logic [DW-1:0] bexp[4];
  logic [1:0]    bres[4];

  initial begin
    rst = 1'b1; in_valid = 0; out_ready = 0; clr_stats = 0;
    in_codeword = '0; in_erasure = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_result", out_result, 2'b00);
    chk("rst_fix", out_fix_cnt, 2'd0);
    chk("rst_ce", ce_cnt, 16'd0);
    chk("rst_due", due_cnt, 16'd0);

    D = 64'h0123456789ABCDEF;
    run_vec("e0_sym3",   sm(3, 8'h5A), 10'h000, '0, CE, 2'd1);
    run_vec("e2_1_6",    sm(1, 8'h11) ^ sm(6, 8'hF0), 10'h042, '0, CE, 2'd2);
    run_vec("e2_7_9",    sm(7, 8'h22) ^ sm(9, 8'h44), 10'h280, '0, CE, 2'd2);
    run_vec("e1_mismatch", sm(5, 8'h33), 10'h004, 64'h0000_0000_0033_0000, DUE, 2'd0);
    run_vec("e3_clean",  '0, 10'h007, '0, DUE, 2'd0);
    run_vec("e2_clean",  '0, 10'h003, '0, NE, 2'd0);
    run_vec("e0_loc_oob", sm(8, 8'h01) ^ sm(9, 8'h1D), 10'h000, '0, DUE, 2'd0);
    run_vec("clean_d",   enc(D), 10'h000, D, NE, 2'd0);
    run_vec("e0_sym0",   enc(D) ^ sm(0, 8'hFF), 10'h000, D, CE, 2'd1);
    run_vec("e2_2_7",    enc(D) ^ sm(2, 8'h3C) ^ sm(7, 8'h80), 10'h084, D, CE, 2'd2);
    run_vec("e1_sym4",   enc(D) ^ sm(4, 8'h9A), 10'h010, D, CE, 2'd1);
    run_vec("e2_3_p0",   enc(D) ^ sm(3, 8'h55) ^ sm(8, 8'h0F), 10'h108, D, CE, 2'd2);
    run_vec("e0_p1",     enc(D) ^ sm(9, 8'h21), 10'h000, D, CE, 2'd1);
    run_vec("e1_p0",     enc(D) ^ sm(8, 8'h77), 10'h100, D, CE, 2'd1);
    run_vec("e2_p0_p1",  enc(D) ^ sm(8, 8'h12) ^ sm(9, 8'h34), 10'h300, D, CE, 2'd2);
    run_vec("e2_one_err", enc(D) ^ sm(2, 8'h44), 10'h084, D, CE, 2'd1);
    run_vec("e1_p0_bad", enc(D) ^ sm(9, 8'h21), 10'h100, D, DUE, 2'd0);

    @(negedge clk);
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    exp_ce = 0;
    exp_due = 0;
    chk("clr_ce", ce_cnt, 16'd0);
    chk("clr_due", due_cnt, 16'd0);

    bexp[0] = D;                     bcw[0] = enc(bexp[0]);                                   ber[0] = 10'h000; bres[0] = NE;
    bexp[1] = ~D;                    bcw[1] = enc(bexp[1]) ^ sm(3, 8'h42);                    ber[1] = 10'h000; bres[1] = CE;
    bexp[2] = 64'h1122334455667788;  bcw[2] = enc(bexp[2]) ^ sm(0, 8'h01) ^ sm(5, 8'h80);     ber[2] = 10'h021; bres[2] = CE;
    bexp[3] = 64'h0F1E2D3C4B5A6978;  bcw[3] = enc(bexp[3]);                                   ber[3] = 10'h000; bres[3] = NE;
    begin
      int n_s, n_r, extra;
      logic saw_low, hs_in, hs_out;
      n_s = 0; n_r = 0; extra = 0; saw_low = 0;
      for (int cyc = 0; cyc < 40 && n_r < 4; cyc++) begin
        @(negedge clk);
        out_ready = (cyc >= 5);
        if (n_s < 4) begin
          in_valid    = 1'b1;
          in_codeword = bcw[n_s];
          in_erasure  = ber[n_s];
        end else begin
          in_valid = 1'b0;
        end
        #1;
        if (!in_ready) saw_low = 1'b1;
        hs_in  = in_valid && in_ready;
        hs_out = out_valid && out_ready;
        if (hs_out) begin
          chk("bp_data", out_data, bexp[n_r]);
          chk("bp_res", out_result, bres[n_r]);
          bump(bres[n_r]);
          n_r++;
        end
        @(posedge clk);
        if (hs_in) n_s++;
      end
      in_valid = 1'b0;
      chk("bp_in_ready_low", saw_low, 1'b1);
      chk("bp_sent", n_s, 4);
      chk("bp_recv", n_r, 4);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (out_valid) extra++;
      end
      chk("bp_no_dup", extra, 0);
      chk("bp_ce", ce_cnt, exp_ce);
      chk("bp_due", due_cnt, exp_due);
    end

    begin
      int stale;
      stale = 0;
      @(negedge clk);
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      in_codeword = enc(D) ^ sm(1, 8'h0A);
      in_erasure  = '0;
      @(negedge clk);
      in_codeword = enc(~D);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_ce", ce_cnt, 16'd0);
      chk("mid_rst_due", due_cnt, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (out_valid) stale++;
      end
      chk("mid_rst_stale", stale, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
